// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, widths and the parity helper used by
// both the receive and transmit engines.
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2
   } rx_state_t;

   localparam int UART_K_W      = 19;
   localparam int UART_MAX_BITS = 11;

   // Even parity is the XOR of the data bits; odd is its inverse.
   // In 7-bit mode bit 7 is excluded.
   function automatic logic parity_calc(
      input logic [7:0] data,
      input logic       eight,
      input logic       odd
   );
      return (^{eight & data[7], data[6:0]}) ^ odd;
   endfunction

endpackage

// File: rtl/bit_time_counter.sv
// bit_time_counter: free-running count 0..tc, wrapping to 0 at terminal.
// Ports: clk, rst (sync active-low), clr, en, tc (terminal), done (count==tc).
module bit_time_counter
   import uart_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                en,
   input  logic [UART_K_W-1:0] tc,
   output logic                done
);

   logic [UART_K_W-1:0] count;

   assign done = (count == tc);

   always_ff @(posedge clk) begin
      if (!rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= done ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/uart_receive.sv
// uart_receive: UART RX engine; start detect, mid-bit sampling, status.
// Ports: clk, rst (sync active-low), rx, eight, pen, ohel, k, read ->
//        rxrdy, rx_data, perr, ferr, ovf. Option: UART_RX_SYNC_EN.
module uart_receive
   import uart_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                rx,
   input  logic                eight,
   input  logic                pen,
   input  logic                ohel,
   input  logic [UART_K_W-1:0] k,
   input  logic                read,
   output logic                rxrdy,
   output logic [7:0]          rx_data,
   output logic                perr,
   output logic                ferr,
   output logic                ovf
);

   logic rxs;

`ifdef UART_RX_SYNC_EN
   logic [1:0] sync_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], rx};
      end
   end

   assign rxs = sync_q[1];
`else
   assign rxs = rx;
`endif

   rx_state_t           state;
   logic [3:0]          bit_cnt;
   logic [9:0]          shift;
   logic                fin;
   logic [UART_K_W-1:0] tc;
   logic                cnt_clr;
   logic                btu;
   logic [3:0]          m;
   logic [3:0]          bit_nxt;

   // The detection edge in IDLE counts as tick 0 of the half bit, so
   // with k=0 or 1 the start bit is confirmed on that same edge.
   always_comb begin
      tc      = (state == ST_DATA) ? k : (k >> 1);
      cnt_clr = (state == ST_IDLE) && rxs;
   end

   bit_time_counter u_btc (
      .clk  (clk),
      .rst  (rst),
      .clr  (cnt_clr),
      .en   (1'b1),
      .tc   (tc),
      .done (btu)
   );

   assign m       = 4'd8 + {3'b000, eight} + {3'b000, pen};
   assign bit_nxt = bit_cnt + 4'd1;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= ST_IDLE;
         bit_cnt <= '0;
         shift   <= '1;
         fin     <= 1'b0;
      end else begin
         fin <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               bit_cnt <= '0;
               if (!rxs) begin
                  state <= btu ? ST_DATA : ST_START;
               end
            end
            ST_START: begin
               if (btu) begin
                  state <= rxs ? ST_IDLE : ST_DATA;
               end
            end
            ST_DATA: begin
               if (btu) begin
                  shift   <= {rxs, shift[9:1]};
                  bit_cnt <= bit_nxt;
                  // Saturation guards against config changed mid-frame.
                  if (bit_nxt == m ||
                      bit_nxt >= 4'(UART_MAX_BITS)) begin
                     state <= ST_IDLE;
                     fin   <= 1'b1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   logic [9:0] frame;
   logic [7:0] data_w;
   logic       par_rx;
   logic       stop_rx;
   logic       par_exp;

   always_comb begin
      frame   = shift >> (4'd10 - m);
      data_w  = eight ? frame[7:0] : {1'b0, frame[6:0]};
      par_rx  = frame[m - 4'd2];
      stop_rx = frame[m - 4'd1];
      par_exp = parity_calc(frame[7:0], eight, ohel);
   end

   // Completion beats a same-cycle read: fresh byte stays ready and
   // the overrun is not flagged because the old byte was consumed.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rxrdy   <= 1'b0;
         rx_data <= '0;
         perr    <= 1'b0;
         ferr    <= 1'b0;
         ovf     <= 1'b0;
      end else if (fin) begin
         rxrdy   <= 1'b1;
         rx_data <= data_w;
         perr    <= pen & (par_rx ^ par_exp);
         ferr    <= ~stop_rx;
         ovf     <= rxrdy & ~read;
      end else if (read) begin
         rxrdy <= 1'b0;
         perr  <= 1'b0;
         ferr  <= 1'b0;
         ovf   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_receive.sv
// tb_uart_receive: directed scenario bench for uart_receive.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_receive;

   logic        clk;
   logic        rst;
   logic        rx;
   logic        eight;
   logic        pen;
   logic        ohel;
   logic [18:0] k;
   logic        read;
   logic        rxrdy;
   logic [7:0]  rx_data;
   logic        perr;
   logic        ferr;
   logic        ovf;

   int checks = 0;
   int errors = 0;

   uart_receive dut (
      .clk     (clk),
      .rst     (rst),
      .rx      (rx),
      .eight   (eight),
      .pen     (pen),
      .ohel    (ohel),
      .k       (k),
      .read    (read),
      .rxrdy   (rxrdy),
      .rx_data (rx_data),
      .perr    (perr),
      .ferr    (ferr),
      .ovf     (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Bit 0 is the start bit, then data LSB first, parity, stop.
   function automatic logic [10:0] mk_frame(
      input  logic [7:0] d,
      input  logic       e8,
      input  logic       pe,
      input  logic       pb,
      input  logic       sb,
      output int         n
   );
      logic [10:0] f;
      int idx;
      f = '1;
      f[0] = 1'b0;
      idx = 1;
      for (int i = 0; i < (e8 ? 8 : 7); i++) begin
         f[idx] = d[i];
         idx++;
      end
      if (pe) begin
         f[idx] = pb;
         idx++;
      end
      f[idx] = sb;
      n = idx + 1;
      return f;
   endfunction

   task automatic drive_bits(input logic [10:0] b, input int n,
                             input int kk);
      for (int i = 0; i < n; i++) begin
         rx = b[i];
         tick(kk + 1);
      end
   endtask

   task automatic pulse_read;
      read = 1'b1;
      tick(1);
      read = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b0; rx = 1'b1; read = 1'b0;
      eight = 1'b1; pen = 1'b1; ohel = 1'b0; k = 19'd4;
      tick(3);
      checks += 5;
      if (rxrdy !== 1'b0) begin
         errors++; $display("FAIL reset_rxrdy got %b exp 0", rxrdy);
      end
      if (rx_data !== 8'h00) begin
         errors++; $display("FAIL reset_data got %h exp 00", rx_data);
      end
      if (perr !== 1'b0) begin
         errors++; $display("FAIL reset_perr got %b exp 0", perr);
      end
      if (ferr !== 1'b0) begin
         errors++; $display("FAIL reset_ferr got %b exp 0", ferr);
      end
      if (ovf !== 1'b0) begin
         errors++; $display("FAIL reset_ovf got %b exp 0", ovf);
      end
      rst = 1'b1;
      tick(2);
   endtask

   task automatic test_basic;
      logic [10:0] f;
      int n;
      eight = 1'b1; pen = 1'b1; ohel = 1'b0; k = 19'd4;
      f = mk_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, n);
      drive_bits(f, n - 1, 4);
      rx = 1'b1;
      tick(3);
      checks++;
      if (rxrdy !== 1'b0) begin
         errors++; $display("FAIL basic_early got %b exp 0", rxrdy);
      end
      tick(1);
      checks += 4;
      if (rxrdy !== 1'b1) begin
         errors++; $display("FAIL basic_rxrdy got %b exp 1", rxrdy);
      end
      if (rx_data !== 8'hA5) begin
         errors++; $display("FAIL basic_data got %h exp a5", rx_data);
      end
      if (perr !== 1'b0) begin
         errors++; $display("FAIL basic_perr got %b exp 0", perr);
      end
      if (ferr !== 1'b0) begin
         errors++; $display("FAIL basic_ferr got %b exp 0", ferr);
      end
      tick(2);
      pulse_read;
      checks++;
      if (rxrdy !== 1'b0) begin
         errors++; $display("FAIL basic_read got %b exp 0", rxrdy);
      end
   endtask

   task automatic test_parity_err;
      logic [10:0] f;
      int n;
      f = mk_frame(8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, n);
      drive_bits(f, n, 4);
      rx = 1'b1;
      tick(2);
      checks += 3;
      if (rx_data !== 8'hA5) begin
         errors++; $display("FAIL par_data got %h exp a5", rx_data);
      end
      if (perr !== 1'b1) begin
         errors++; $display("FAIL par_perr got %b exp 1", perr);
      end
      if (rxrdy !== 1'b1) begin
         errors++; $display("FAIL par_rxrdy got %b exp 1", rxrdy);
      end
      pulse_read;
      checks += 4;
      if ({rxrdy, perr, ferr, ovf} !== 4'b0000) begin
         errors++;
         $display("FAIL par_clr got %b exp 0000", {rxrdy, perr, ferr, ovf});
      end
      if (rx_data !== 8'hA5) begin
         errors++; $display("FAIL par_hold got %h exp a5", rx_data);
      end
      tick(1);
      if (rxrdy !== 1'b0) begin
         errors++; $display("FAIL par_stay got %b exp 0", rxrdy);
      end
      if (perr !== 1'b0) begin
         errors++; $display("FAIL par_perr_clr got %b exp 0", perr);
      end
   endtask

   task automatic test_framing;
      logic [10:0] f;
      int n;
      eight = 1'b0; pen = 1'b0; k = 19'd4;
      f = mk_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, n);
      drive_bits(f, n, 4);
      rx = 1'b1;
      tick(6);
      checks += 4;
      if (rx_data !== 8'h55) begin
         errors++; $display("FAIL frm_data got %h exp 55", rx_data);
      end
      if (ferr !== 1'b1) begin
         errors++; $display("FAIL frm_ferr got %b exp 1", ferr);
      end
      if (perr !== 1'b0) begin
         errors++; $display("FAIL frm_perr got %b exp 0", perr);
      end
      if (rxrdy !== 1'b1) begin
         errors++; $display("FAIL frm_rxrdy got %b exp 1", rxrdy);
      end
      pulse_read;
      tick(2);
   endtask

   task automatic test_false_start;
      logic [10:0] f;
      int n;
      eight = 1'b1; pen = 1'b0; k = 19'd8;
      rx = 1'b0;
      tick(2);
      rx = 1'b1;
      tick(20);
      checks++;
      if (rxrdy !== 1'b0) begin
         errors++; $display("FAIL fs_rxrdy got %b exp 0", rxrdy);
      end
      f = mk_frame(8'hC3, 1'b1, 1'b0, 1'b0, 1'b1, n);
      drive_bits(f, n, 8);
      rx = 1'b1;
      tick(2);
      checks += 2;
      if (rx_data !== 8'hC3) begin
         errors++; $display("FAIL fs_data got %h exp c3", rx_data);
      end
      if (ferr !== 1'b0) begin
         errors++; $display("FAIL fs_ferr got %b exp 0", ferr);
      end
      pulse_read;
      tick(2);
   endtask

   task automatic test_back_to_back;
      logic [10:0] f;
      int n;
      eight = 1'b1; pen = 1'b0; k = 19'd4;
      f = mk_frame(8'h12, 1'b1, 1'b0, 1'b0, 1'b1, n);
      drive_bits(f, n, 4);
      f = mk_frame(8'h34, 1'b1, 1'b0, 1'b0, 1'b1, n);
      drive_bits(f, n, 4);
      rx = 1'b1;
      tick(2);
      checks += 3;
      if (rx_data !== 8'h34) begin
         errors++; $display("FAIL ovf_data got %h exp 34", rx_data);
      end
      if (ovf !== 1'b1) begin
         errors++; $display("FAIL ovf_set got %b exp 1", ovf);
      end
      if (rxrdy !== 1'b1) begin
         errors++; $display("FAIL ovf_rxrdy got %b exp 1", rxrdy);
      end
      pulse_read;
      checks++;
      if (ovf !== 1'b0) begin
         errors++; $display("FAIL ovf_clr got %b exp 0", ovf);
      end
      f = mk_frame(8'h12, 1'b1, 1'b0, 1'b0, 1'b1, n);
      drive_bits(f, n, 4);
      rx = 1'b1;
      tick(2);
      f = mk_frame(8'h34, 1'b1, 1'b0, 1'b0, 1'b1, n);
      drive_bits(f, n - 1, 4);
      rx = 1'b1;
      tick(3);
      read = 1'b1;
      tick(1);
      read = 1'b0;
      checks += 4;
      if (rxrdy !== 1'b1) begin
         errors++; $display("FAIL rdwin_rxrdy got %b exp 1", rxrdy);
      end
      if (rx_data !== 8'h34) begin
         errors++; $display("FAIL rdwin_data got %h exp 34", rx_data);
      end
      if (ovf !== 1'b0) begin
         errors++; $display("FAIL rdwin_ovf got %b exp 0", ovf);
      end
      tick(1);
      if (rxrdy !== 1'b1) begin
         errors++; $display("FAIL rdwin_hold got %b exp 1", rxrdy);
      end
      pulse_read;
      tick(2);
   endtask

   task automatic test_reset_mid;
      logic [10:0] f;
      int n;
      eight = 1'b1; pen = 1'b0; k = 19'd4;
      f = mk_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, n);
      drive_bits(f, 4, 4);
      tick(2);
      rst = 1'b0;
      tick(1);
      rst = 1'b1;
      rx = 1'b1;
      tick(10);
      checks++;
      if (rxrdy !== 1'b0) begin
         errors++; $display("FAIL rmid_idle got %b exp 0", rxrdy);
      end
      drive_bits(f, n, 4);
      rx = 1'b1;
      tick(2);
      checks += 2;
      if (rx_data !== 8'h3C) begin
         errors++; $display("FAIL rmid_data got %h exp 3c", rx_data);
      end
      if ({rxrdy, perr, ferr, ovf} !== 4'b1000) begin
         errors++;
         $display("FAIL rmid_flags got %b exp 1000", {rxrdy, perr, ferr, ovf});
      end
      pulse_read;
      tick(2);
   endtask

   task automatic test_k0;
      logic [10:0] f;
      int n;
      eight = 1'b1; pen = 1'b1; ohel = 1'b1; k = 19'd0;
      f = mk_frame(8'h81, 1'b1, 1'b1, 1'b1, 1'b1, n);
      drive_bits(f, n, 0);
      rx = 1'b1;
      tick(3);
      checks += 3;
      if (rx_data !== 8'h81) begin
         errors++; $display("FAIL k0_data got %h exp 81", rx_data);
      end
      if (perr !== 1'b0) begin
         errors++; $display("FAIL k0_perr got %b exp 0", perr);
      end
      if (rxrdy !== 1'b1) begin
         errors++; $display("FAIL k0_rxrdy got %b exp 1", rxrdy);
      end
      pulse_read;
      f = mk_frame(8'h81, 1'b1, 1'b1, 1'b0, 1'b1, n);
      drive_bits(f, n, 0);
      rx = 1'b1;
      tick(3);
      checks++;
      if (perr !== 1'b1) begin
         errors++; $display("FAIL k0_perr_odd got %b exp 1", perr);
      end
      pulse_read;
      tick(2);
   endtask

   initial begin
      rst = 1'b0; rx = 1'b1; read = 1'b0;
      eight = 1'b1; pen = 1'b1; ohel = 1'b0; k = 19'd4;
      test_reset;
      test_basic;
      test_parity_err;
      test_framing;
      test_false_start;
      test_back_to_back;
      test_reset_mid;
      test_k0;
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_receive.md
# uart_receive

Serial receive engine: the RX-side counterpart of the UART transmit engine, consuming the line format the transmitter produces. Detects the start bit, samples each bit at mid-bit using the same `k` bit-time count, deserialises data, parity and stop, and presents a byte with status flags. A `read` strobe from the host handshakes the byte out. Sits between the RX pad and the processor's input port.

## Interface
Parameters:
- none; bit time is the runtime input `k`.

Ports:
- `clk`  in  1  system clock; the block's only clock.
- `rst`  in  1  active-low reset, synchronous to `clk`.
- `rx`  in  1  serial line, idle high.
- `eight`  in  1  1 = 8 data bits, 0 = 7.
- `pen`  in  1  parity enable.
- `ohel`  in  1  parity sense: 1 = odd, 0 = even.
- `k`  in  19  bit-time terminal count; bit period = `k`+1 clocks.
- `read`  in  1  one-clock strobe: host consumed `rx_data`.
- `rxrdy`  out  1  byte available.
- `rx_data`  out  8  received byte; bit 7 = 0 in 7-bit mode.
- `perr`  out  1  parity error, valid with `rxrdy`.
- `ferr`  out  1  framing error: stop bit sampled 0.
- `ovf`  out  1  overrun: frame completed while `rxrdy` already set.

## Operation
- `rxs` = `rx` after optional synchronizer (see Configuration).
- FSM states: IDLE, START, DATA.
  - IDLE: counters cleared; `rxs`==0 -> START.
  - START: bit-time counter counts 0..`k`>>1; at terminal, `rxs`==0 -> DATA (counter cleared), else false start -> IDLE.
  - DATA: counter counts 0..`k`, BTU at `k`; each BTU samples `rxs` into a 10-bit right-shift register (new bit enters bit 9), increments bit counter.
- Samples after start M = 8 + `eight` + `pen` (data, optional parity, stop). After M-th sample -> IDLE.
- Alignment: frame = shift reg >> (10-M); data LSB first at frame[0]; parity at frame[M-2] when `pen`; stop at frame[M-1].
- Expected parity: even = XOR of data bits (7 or 8 per `eight`), odd = its inverse. `perr` = `pen` & (received != expected); 0 when `pen`=0.
- On completion: load `rx_data`, `perr`, `ferr`; set `rxrdy`; `ovf` set if `rxrdy` was 1 and no `read` that cycle. Old data overwritten.
- `read` clears `rxrdy`, `perr`, `ferr`, `ovf` next clock. Completion and `read` in same cycle: completion wins, `rxrdy` stays 1 with new data, `ovf` not set.
- `eight`/`pen`/`ohel`/`k` must be stable while not IDLE; changes mid-frame give undefined data, no hang (bit counter saturates to IDLE at 11).

## Timing
- Reset (`rst`=0 at posedge): state IDLE, counters 0, shift reg all 1, `rxrdy`/`perr`/`ferr`/`ovf`=0, `rx_data`=0. Reset mid-frame discards the frame.
- Start sample at (`k`>>1)+1 clocks after `rxs` falls; each later sample `k`+1 clocks apart.
- `rxrdy` rises one clock after the stop-bit sample.
- Return to IDLE at stop sample (mid stop bit): next start edge detected with no dead time.
- `k`=0: one sample per clock, must function.

## Configuration
- `UART_RX_SYNC_EN` defined: two-flop synchronizer on `rx` (reset to 1); all sample points delayed 2 clocks relative to pin.
- Undefined: `rxs` = `rx` directly; for synchronous benches only.

## Structure
- Shared `uart_pkg`: FSM state enum, `UART_K_W`=19, max frame bits 11, parity-compute function shared with transmit.
- One sub-module: `bit_time_counter` (19-bit counter, terminal compare, clear/enable), reusable by transmit.

## Test plan
- `k`=4, eight=1 pen=1 ohel=0, send 0xA5 parity 0 stop 1 -> `rxrdy`=1 one clock after stop sample, `rx_data`=0xA5, `perr`=`ferr`=0.
- Same, parity bit 1 -> `rx_data`=0xA5, `perr`=1; `read` -> all flags 0 next clock.
- eight=0 pen=0, send 7-bit 0x55 then stop 0 -> `rx_data`=0x55, `ferr`=1.
- `rx` low for 2 clocks then high (`k`=8) -> START aborts to IDLE, `rxrdy` stays 0.
- Two frames 0x12, 0x34 with no `read` -> `rx_data`=0x34, `ovf`=1; second run with `read` on completion cycle -> `rxrdy`=1, `ovf`=0.
- `rst`=0 mid-data-bit, then full 0x3C frame -> only 0x3C reported, flags 0.
